// File: rtl/muskbus_pkg.sv
// rtl/muskbus_pkg.sv - shared types and constants for the Muskbus line reader
package muskbus_pkg;

    localparam int LINE_BYTES     = 64;
    localparam int BEAT_BITS      = 64;
    localparam int BEATS_PER_LINE = 8;
    localparam int TAG_BITS       = 16;

    localparam logic [3:0] MUSKBUS_READ   = 4'h1;
    localparam logic [3:0] MUSKBUS_MEMORY = 4'h2;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    // Byte 0 of the little-endian beat lands in the leftmost byte lane of the line.
    function automatic logic [BEAT_BITS-1:0] bswap64(input logic [BEAT_BITS-1:0] v);
        logic [BEAT_BITS-1:0] r;
        for (int j = 0; j < 8; j++) begin
            r[BEAT_BITS-1-8*j -: 8] = v[8*j +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/muskbus_if.sv
// rtl/muskbus_if.sv - Muskbus request/response interface
interface Muskbus;
    logic                             reqcyc;
    logic [63:0]                      req;
    logic [muskbus_pkg::TAG_BITS-1:0] reqtag;
    logic                             reqack;
    logic                             respcyc;
    logic [63:0]                      resp;
    logic [muskbus_pkg::TAG_BITS-1:0] resptag;
    logic                             respack;

    modport Top (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/muskbus_beat_assembler.sv
// rtl/muskbus_beat_assembler.sv - beat counter and byte-swapping line register
module muskbus_beat_assembler
    import muskbus_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    beat_valid,
    input  logic [BEAT_BITS-1:0]    beat,
    output logic [0:LINE_BYTES*8-1] line,
    output logic                    last_beat
);

    logic [2:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_valid) begin
            line[{beat_cnt, 6'b0} +: BEAT_BITS] <= bswap64(beat);
            beat_cnt                            <= beat_cnt + 3'd1;
        end
    end

    assign last_beat = beat_valid && (beat_cnt == 3'(BEATS_PER_LINE - 1));

endmodule

// File: rtl/muskbus_reader.sv
// rtl/muskbus_reader.sv - single-outstanding 64-byte line read engine on Muskbus
module muskbus_reader #(
    parameter int LINE_BYTES = 64,
    parameter int BEAT_BITS  = 64
) (
    input  logic                    reset,
    input  logic                    clk,
    Muskbus.Top                     bus,
    input  logic                    reqcyc,
    input  logic [63:0]             addr,
    output logic                    respcyc,
    output logic [0:LINE_BYTES*8-1] data
);
    import muskbus_pkg::*;

    localparam int OFF_BITS = $clog2(LINE_BYTES);

    state_e               state, state_next;
    logic [63:0]          line_addr;
    logic                 clear_cnt;
    logic                 beat_valid;
    logic                 last_beat;
    logic [BEAT_BITS-1:0] beat;
    logic                 unused_ok;

    assign unused_ok = ^{addr[OFF_BITS-1:0], bus.resptag};
    assign beat      = bus.resp;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset)
            line_addr <= '0;
        else if (state == IDLE && reqcyc)
            line_addr <= {addr[63:OFF_BITS], {OFF_BITS{1'b0}}};
    end

    always_comb begin
        state_next  = state;
        bus.reqcyc  = 1'b0;
        bus.respack = 1'b0;
        respcyc     = 1'b0;
        beat_valid  = 1'b0;
        clear_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (reqcyc) begin
                    clear_cnt  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                bus.reqcyc = 1'b1;
                if (bus.reqack) state_next = RESP;
            end
            RESP: begin
                // Only one transaction is in flight, so the response tag is never matched.
                bus.respack = bus.respcyc;
                beat_valid  = bus.respcyc;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                respcyc    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req    = line_addr;
    assign bus.reqtag = {MUSKBUS_READ, MUSKBUS_MEMORY, 8'h00};

    muskbus_beat_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_cnt),
        .beat_valid (beat_valid),
        .beat       (beat),
        .line       (data),
        .last_beat  (last_beat)
    );

endmodule

// File: tb/tb_muskbus_reader.sv
// tb/tb_muskbus_reader.sv - scoreboard bench for muskbus_reader with a Muskbus memory model
module tb_muskbus_reader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         reqcyc = 1'b0;
    logic [63:0]  addr = '0;
    logic         respcyc;
    logic [0:511] data;

    Muskbus bus();

    muskbus_reader #(.LINE_BYTES(64), .BEAT_BITS(64)) dut (
        .reset   (reset),
        .clk     (clk),
        .bus     (bus),
        .reqcyc  (reqcyc),
        .addr    (addr),
        .respcyc (respcyc),
        .data    (data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [15:0] EXP_TAG = 16'h1200;

    typedef struct {
        logic [0:511] line;
        int           lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] addr_q[$];
    int          req_cyc_q[$];
    int          resp_cyc_q[$];
    int          last_req_cyc = 0;
    int          req_count = 0;
    int          txn_done = 0;
    int          m_ack = 0;
    int          m_gap = 0;
    int          m_rst = -1;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [0:511] exp_line(input logic [7:0] seed);
        logic [0:511] l;
        for (int k = 0; k < 64; k++) l[k*8 +: 8] = 8'(k) ^ seed;
        return l;
    endfunction

    function automatic logic [63:0] beat_val(input int i, input logic [7:0] seed);
        return (64'h0706050403020100 + 64'(i) * 64'h0808080808080808) ^ {8{seed}};
    endfunction

    function automatic logic [7:0] seed_of(input logic [63:0] a);
        return a[13:6] ^ 8'h01;
    endfunction

    // Memory model: sole driver of reset and of the bus inputs.
    initial begin : mem_model
        logic [63:0] ea;
        logic [7:0]  sd;
        logic        exp_ack;
        bus.reqack  = 1'b0;
        bus.respcyc = 1'b0;
        bus.resp    = '0;
        bus.resptag = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.reqcyc === 1'b1) begin
                req_count++;
                last_req_cyc = cyc;
                req_cyc_q.push_back(cyc);
                if (addr_q.size() == 0) begin
                    ea = bus.req;
                    tests++; fails++;
                    $display("FAIL unexpected_bus_req: got %0h expected none", bus.req);
                end else begin
                    ea = addr_q.pop_front();
                    chk("bus_req_addr", 512'(bus.req), 512'(ea));
                end
                chk("bus_reqtag", 512'(bus.reqtag), 512'(EXP_TAG));
                sd = seed_of(ea);
                for (int d = 0; d < m_ack; d++) begin
                    @(negedge clk);
                    chk("req_hold", 512'({bus.reqcyc, bus.req, bus.reqtag}), 512'({1'b1, ea, EXP_TAG}));
                end
                bus.reqack = 1'b1;
                @(negedge clk);
                bus.reqack = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (m_rst >= 0 && i == m_rst + 1) begin
                        reset = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        chk("rst_bus_reqcyc", 512'(bus.reqcyc), 512'(0));
                        chk("rst_respcyc", 512'(respcyc), 512'(0));
                        chk("rst_data", data, '0);
                    end
                    exp_ack = (m_rst < 0) || (i <= m_rst);
                    bus.respcyc = 1'b1;
                    bus.resp    = beat_val(i, sd);
                    bus.resptag = EXP_TAG;
                    #1 chk("respack_beat", 512'(bus.respack), 512'(exp_ack));
                    @(negedge clk);
                    bus.respcyc = 1'b0;
                    if (i < 7) begin
                        for (int g = 0; g < m_gap; g++) begin
                            #1 chk("respack_gap", 512'(bus.respack), 512'(0));
                            @(negedge clk);
                        end
                    end
                end
                txn_done++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (respcyc === 1'b1) begin
                resp_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_respcyc: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("line_data", data, e.line);
                    chk("latency", 512'(cyc - last_req_cyc + 2), 512'(e.lat));
                end
            end
        end
    end

    task automatic wait_resp(input string name);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (respcyc === 1'b1) break;
        end
        if (n == 300) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no respcyc expected one within 300 cycles", name);
        end
    endtask

    task automatic pulse_req(input logic [63:0] a);
        @(negedge clk);
        reqcyc = 1'b1;
        addr   = a;
        @(negedge clk);
        reqcyc = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int rc;
        int done0;
        int n;
        repeat (3) @(negedge clk);
        chk("reset_bus_reqcyc", 512'(bus.reqcyc), 512'(0));
        chk("reset_respack", 512'(bus.respack), 512'(0));
        chk("reset_respcyc", 512'(respcyc), 512'(0));
        chk("reset_data", data, '0);

        // Single unstalled read
        addr_q.push_back(64'h0000_0000_1000_0040);
        sb_q.push_back('{exp_line(8'h00), 11});
        pulse_req(64'h0000_0000_1000_0047);
        wait_resp("single");

        // Ack delayed 5 cycles, 2 idle cycles between beats
        m_ack = 5; m_gap = 2;
        addr_q.push_back(64'h0000_0000_1000_0040);
        sb_q.push_back('{exp_line(8'h00), 30});
        pulse_req(64'h0000_0000_1000_0047);
        wait_resp("stall");
        m_ack = 0; m_gap = 0;
        repeat (3) @(negedge clk);

        // Back-to-back with reqcyc held high
        addr_q.push_back(64'h0000_0000_0004_0100);
        addr_q.push_back(64'h0000_0000_0004_0140);
        sb_q.push_back('{exp_line(8'h05), 11});
        sb_q.push_back('{exp_line(8'h04), 11});
        @(negedge clk);
        reqcyc = 1'b1;
        addr   = 64'h0000_0000_0004_0100;
        wait_resp("b2b_first");
        addr = 64'h0000_0000_0004_0140;
        wait_resp("b2b_second");
        reqcyc = 1'b0;
        #1;
        chk("b2b_gap", 512'(req_cyc_q[req_cyc_q.size()-1] - resp_cyc_q[resp_cyc_q.size()-2]), 512'(2));
        repeat (3) @(negedge clk);

        // Request withdrawn after one cycle
        addr_q.push_back(64'h0000_0000_0008_00C0);
        sb_q.push_back('{exp_line(8'h02), 11});
        pulse_req(64'h0000_0000_0008_00C7);
        wait_resp("withdrawn");
        rc = req_count;
        repeat (20) @(negedge clk);
        chk("no_extra_req", 512'(req_count), 512'(rc));

        // Reset after beat 3, stray beats follow, then a fresh request
        m_rst = 3;
        done0 = txn_done;
        addr_q.push_back(64'h0000_0000_2000_0000);
        pulse_req(64'h0000_0000_2000_0000);
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (txn_done != done0) break;
        end
        if (n == 300) begin
            tests++; fails++;
            $display("FAIL reset_txn_timeout: got no completion expected one within 300 cycles");
        end
        m_rst = -1;
        repeat (2) @(negedge clk);
        addr_q.push_back(64'h0000_0000_2000_0100);
        sb_q.push_back('{exp_line(8'h05), 11});
        pulse_req(64'h0000_0000_2000_0100);
        wait_resp("after_reset");

        // Idle
        repeat (2) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_quiet", 512'({bus.reqcyc, bus.respack, respcyc}), 512'(0));
        end

        chk("sb_drained", 512'(sb_q.size()), 512'(0));
        chk("addr_q_drained", 512'(addr_q.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
